planta_engarrafamento: RTL and testbench

Behavioural plant emulator for the bottling line, sitting on the far side of the main controller's actuator/sensor interface.
- Consumes controller commands MOTOR, EV and VE.
- Produces the sensor levels PG, CH, RO, CQ, EB and IR.
- Lets the main state machine and the cork/dozen counters run closed-loop on the board and in simulation, without push-button stimulus.
- Models one bottle at a time moving along the belt, the filling station, the corking station and the cork hopper.

---
 rtl/planta_engarrafamento_if.sv | 39 +++
 rtl/planta_engarrafamento.sv | 222 ++++++++++++++++++++++
 tb/tb_planta_engarrafamento.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/planta_engarrafamento_if.sv
// Actuator/sensor bus between the bottling-line controller and the plant
// emulator.
//   master : controller side, drives MOTOR/EV/VE and reads the sensors
//   slave  : plant side, reads the commands and drives the sensors
// Signals:
//   MOTOR    belt motor command (1 = running)
//   EV       filling valve command (1 = open)
//   VE       corking actuator command (rising edge inserts one cork)
//   PG       bottle present at filling station
//   CH       current bottle full
//   RO       bottle present at corking station
//   CQ       quality result (1 = approved)
//   EB       one-clock pulse when a bottle leaves the belt
//   IR       one-clock pulse per cork added during hopper refill
//   stock    hopper cork count
//   overflow sticky: valve held open on a full bottle
interface planta_engarrafamento_if;
  logic       MOTOR;
  logic       EV;
  logic       VE;
  logic       PG;
  logic       CH;
  logic       RO;
  logic       CQ;
  logic       EB;
  logic       IR;
  logic [7:0] stock;
  logic       overflow;

  modport master (
    output MOTOR, EV, VE,
    input  PG, CH, RO, CQ, EB, IR, stock, overflow
  );

  modport slave (
    input  MOTOR, EV, VE,
    output PG, CH, RO, CQ, EB, IR, stock, overflow
  );
endinterface

// File: rtl/planta_engarrafamento.sv
// Behavioural bottling-line plant emulator. Takes the controller's actuator
// commands and produces the sensor levels a real belt would, so the main
// controller can be exercised closed-loop. One bottle travels the belt at a
// time through the filling and corking stations; a cork hopper with automatic
// refill feeds the corking station.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high reset
//   bus    planta_engarrafamento_if.slave (commands in, sensors out)
// Optional build macro:
//   REJECT_INJECT_EN  8-bit LFSR that forces occasional quality rejects
module planta_engarrafamento #(
  parameter int TICK_DIV     = 4,
  parameter int BELT_LEN     = 16,
  parameter int FILL_POS     = 4,
  parameter int CORK_POS     = 9,
  parameter int FILL_TICKS   = 6,
  parameter int CORK_CAP     = 20,
  parameter int REFILL_LEVEL = 5,
  parameter int SPAWN_GAP    = 3
) (
  input logic                  clock,
  input logic                  reset,
  planta_engarrafamento_if.slave bus
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int POS_W = (BELT_LEN > 1) ? $clog2(BELT_LEN) : 1;
  localparam int LVL_W = (FILL_TICKS > 1) ? $clog2(FILL_TICKS + 1) : 1;
  localparam int SPW_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP + 1) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [POS_W-1:0] FILL_P   = POS_W'(FILL_POS);
  localparam logic [POS_W-1:0] CORK_P   = POS_W'(CORK_POS);
  localparam logic [POS_W-1:0] EXIT_P   = POS_W'(BELT_LEN - 1);
  localparam logic [LVL_W-1:0] FULL_L   = LVL_W'(FILL_TICKS);
  localparam logic [SPW_W-1:0] SPW_LAST = SPW_W'(SPAWN_GAP);
  localparam logic [7:0]       CAP      = 8'(CORK_CAP);
  localparam logic [7:0]       LOW      = 8'(REFILL_LEVEL);

  typedef enum logic [2:0] {
    TRAVEL_FILL, AT_FILL, TRAVEL_CORK, AT_CORK, TRAVEL_EXIT, SPAWN
  } state_t;

  state_t           state, state_n;
  logic [PRE_W-1:0] presc;
  logic [POS_W-1:0] pos, pos_n, pos_inc;
  logic [LVL_W-1:0] level, level_n;
  logic [SPW_W-1:0] spawn_cnt, spawn_n, spawn_inc;
  logic [7:0]       stock_q, stock_n;
  logic             corked, corked_n;
  logic             pg_q, pg_n, ch_q, ro_q, ro_n, cq_q, cq_n;
  logic             eb_q, ir_q, ovf_q, ovf_n;
  logic             ve_q, ve_rise, tick, move, consume, exit_ev;
  logic             refill_q, refill_on, refill_n, add;
  logic             reject;

  // Hopper update: a refill increment and a consume in the same clock cancel;
  // the count saturates at capacity and never wraps below zero.
  function automatic logic [7:0] stock_next(input logic [7:0] s,
                                            input logic inc, input logic dec);
    logic [7:0] r;
    r = s;
    if (inc && !dec && s < CAP)       r = s + 8'd1;
    else if (dec && !inc && s != 8'd0) r = s - 8'd1;
    return r;
  endfunction

  assign tick      = (presc == PRE_LAST);
  assign move      = tick && bus.MOTOR;
  assign ve_rise   = bus.VE && !ve_q;
  assign pos_inc   = pos + POS_W'(1);
  assign spawn_inc = spawn_cnt + SPW_W'(1);

  assign refill_on = refill_q || (stock_q < LOW);
  assign add       = tick && refill_on && (stock_q < CAP);
  assign stock_n   = stock_next(stock_q, add, consume);
  assign refill_n  = (stock_n == CAP) ? 1'b0 : refill_on;

`ifdef REJECT_INJECT_EN
  logic [7:0] lfsr;
  always_ff @(posedge clock or posedge reset) begin
    if (reset)        lfsr <= 8'hA5;
    else if (exit_ev) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end
  assign reject = (lfsr[2:0] == 3'b000);
`else
  assign reject = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= TRAVEL_FILL;
    else       state <= state_n;
  end

  always_comb begin
    state_n  = state;
    pos_n    = pos;
    level_n  = level;
    corked_n = corked;
    spawn_n  = spawn_cnt;
    ovf_n    = ovf_q;
    pg_n     = pg_q;
    ro_n     = ro_q;
    cq_n     = cq_q;
    consume  = 1'b0;
    exit_ev  = 1'b0;
    case (state)
      TRAVEL_FILL: if (move) begin
        pos_n = pos_inc;
        if (pos_inc == FILL_P) begin
          state_n = AT_FILL;
          pg_n    = 1'b1;
        end
      end
      AT_FILL: begin
        // Belt motion wins over the valve; a part-filled bottle keeps its level.
        if (move) begin
          pos_n = pos_inc;
          pg_n  = 1'b0;
          if (pos_inc == CORK_P) begin
            state_n = AT_CORK;
            ro_n    = 1'b1;
          end else begin
            state_n = TRAVEL_CORK;
          end
        end else if (tick && bus.EV) begin
          if (level == FULL_L) ovf_n = 1'b1;
          else                 level_n = level + LVL_W'(1);
        end
      end
      TRAVEL_CORK: if (move) begin
        pos_n = pos_inc;
        if (pos_inc == CORK_P) begin
          state_n = AT_CORK;
          ro_n    = 1'b1;
        end
      end
      AT_CORK: begin
        consume = ve_rise && (stock_q != 8'd0);
        if (consume) corked_n = 1'b1;
        cq_n = ch_q && corked_n && !reject;
        if (move) begin
          ro_n = 1'b0;
          if (pos_inc == EXIT_P) exit_ev = 1'b1;
          else begin
            pos_n   = pos_inc;
            state_n = TRAVEL_EXIT;
          end
        end
      end
      TRAVEL_EXIT: if (move) begin
        if (pos_inc == EXIT_P) exit_ev = 1'b1;
        else                   pos_n = pos_inc;
      end
      SPAWN: if (tick) begin
        if (spawn_inc == SPW_LAST) begin
          spawn_n = '0;
          state_n = TRAVEL_FILL;
        end else begin
          spawn_n = spawn_inc;
        end
      end
      default: state_n = TRAVEL_FILL;
    endcase
    // Bottle leaves the belt: clear its attributes and wait for the next one.
    if (exit_ev) begin
      state_n  = SPAWN;
      pos_n    = '0;
      level_n  = '0;
      corked_n = 1'b0;
      cq_n     = 1'b0;
      ovf_n    = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      presc     <= '0;
      pos       <= '0;
      level     <= '0;
      corked    <= 1'b0;
      spawn_cnt <= '0;
      stock_q   <= CAP;
      refill_q  <= 1'b0;
      ve_q      <= 1'b0;
      pg_q      <= 1'b0;
      ch_q      <= 1'b0;
      ro_q      <= 1'b0;
      cq_q      <= 1'b0;
      eb_q      <= 1'b0;
      ir_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      presc     <= tick ? '0 : presc + PRE_W'(1);
      pos       <= pos_n;
      level     <= level_n;
      corked    <= corked_n;
      spawn_cnt <= spawn_n;
      stock_q   <= stock_n;
      refill_q  <= refill_n;
      ve_q      <= bus.VE;
      pg_q      <= pg_n;
      ch_q      <= (level_n == FULL_L);
      ro_q      <= ro_n;
      cq_q      <= cq_n;
      eb_q      <= exit_ev;
      ir_q      <= add;
      ovf_q     <= ovf_n;
    end
  end

  assign bus.PG       = pg_q;
  assign bus.CH       = ch_q;
  assign bus.RO       = ro_q;
  assign bus.CQ       = cq_q;
  assign bus.EB       = eb_q;
  assign bus.IR       = ir_q;
  assign bus.stock    = stock_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_planta_engarrafamento.sv
// Directed bench for planta_engarrafamento with default parameters.
// Expected quality results are queued when a bottle is sent to the exit and
// compared when the EB pulse appears.
module tb_planta_engarrafamento;

  localparam int S_PG = 0, S_RO = 1, S_EB = 2, S_CH = 3, S_IR = 4, S_FULL = 5;

  logic clock;
  logic reset;
  planta_engarrafamento_if bus();

  planta_engarrafamento dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   errors = 0;
  int   checks = 0;
  int   ir_count = 0;
  logic cq_prev = 1'b0;
  logic exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int which);
    case (which)
      S_PG:    return bus.PG;
      S_RO:    return bus.RO;
      S_EB:    return bus.EB;
      S_CH:    return bus.CH;
      S_IR:    return bus.IR;
      S_FULL:  return (bus.stock == 8'd20);
      default: return 1'b0;
    endcase
  endfunction

  // One clock, sampled 1 time unit after the rising edge, followed by the
  // exit scoreboard and IR pulse counting.
  task automatic cyc();
    logic e;
    @(posedge clock);
    #1;
    if (bus.EB === 1'b1) begin
      check("exit_queued", (exp_q.size() > 0), 1'b1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("exit_cq", cq_prev, e);
        check("exit_clear", {bus.CQ, bus.CH, bus.overflow}, 3'b000);
      end
    end
    if (bus.IR === 1'b1) ir_count++;
    cq_prev = bus.CQ;
  endtask

  task automatic wait_for(input int which, input logic val, input int bound,
                          input string tag, output int n);
    n = 0;
    while (sig(which) !== val && n < bound) begin
      cyc();
      n++;
    end
    check(tag, sig(which), val);
  endtask

  task automatic ve_pulse();
    bus.VE = 1'b1;
    cyc();
    bus.VE = 1'b0;
  endtask

  // Unfilled bottle: stop it at the corking station, insert nve corks,
  // then send it to the exit.
  task automatic run_bottle(input int nve, input int exp_stock);
    int n;
    wait_for(S_RO, 1'b1, 300, "rb_ro", n);
    bus.MOTOR = 1'b0;
    for (int k = 0; k < nve; k++) begin
      ve_pulse();
      cyc();
    end
    check("rb_stock", bus.stock, exp_stock);
    check("rb_cq", bus.CQ, 1'b0);
    exp_q.push_back(1'b0);
    bus.MOTOR = 1'b1;
    wait_for(S_EB, 1'b1, 200, "rb_eb", n);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    bus.MOTOR = 1'b0;
    bus.EV    = 1'b0;
    bus.VE    = 1'b0;
    cyc();
    cyc();
    check("reset_outs", {bus.PG, bus.CH, bus.RO, bus.CQ, bus.EB, bus.IR,
                         bus.overflow}, 7'b0);
    check("reset_stock", bus.stock, 8'd20);

    // Free run: PG after 4 ticks, bottle passes both stations and exits.
    reset     = 1'b0;
    bus.MOTOR = 1'b1;
    wait_for(S_PG, 1'b1, 40, "pg_rise", n);
    check("pg_latency", n, 16);
    wait_for(S_RO, 1'b1, 60, "free_ro", n);
    check("free_ro_cq", bus.CQ, 1'b0);
    exp_q.push_back(1'b0);
    wait_for(S_EB, 1'b1, 60, "free_eb", n);
    check("free_stock", bus.stock, 8'd20);

    // Filling: 6 valve ticks to full, 2 more set overflow.
    wait_for(S_PG, 1'b1, 200, "fill_pg", n);
    bus.MOTOR = 1'b0;
    bus.EV    = 1'b1;
    wait_for(S_CH, 1'b1, 60, "fill_ch", n);
    check("fill_ticks", n, 24);
    check("fill_no_ovf", bus.overflow, 1'b0);
    repeat (8) cyc();
    check("fill_ovf", bus.overflow, 1'b1);
    bus.EV    = 1'b0;
    bus.MOTOR = 1'b1;
    wait_for(S_RO, 1'b1, 60, "full_ro", n);
    bus.MOTOR = 1'b0;
    check("full_keep", {bus.CH, bus.overflow, bus.PG}, 3'b110);
    ve_pulse();
    cyc();
    check("full_stock", bus.stock, 8'd19);
    check("full_cq", bus.CQ, 1'b1);
    exp_q.push_back(1'b1);
    bus.MOTOR = 1'b1;
    wait_for(S_EB, 1'b1, 60, "full_eb", n);

    // Unfilled bottle, corked: stock drops but CQ stays 0.
    run_bottle(1, 18);

    // Corks down to 5 (no refill yet), then the 14th cork triggers refill.
    for (int i = 0; i < 13; i++) run_bottle(1, 17 - i);
    wait_for(S_RO, 1'b1, 300, "rf_ro", n);
    bus.MOTOR = 1'b0;
    ir_count  = 0;
    ve_pulse();
    check("rf_low", bus.stock, 8'd4);
    wait_for(S_IR, 1'b1, 12, "rf_first_ir", n);
    check("rf_first_inc", bus.stock, 8'd5);
    // Land a VE edge exactly on the next tick: increment and consume cancel.
    cyc();
    cyc();
    cyc();
    bus.VE = 1'b1;
    cyc();
    check("rf_cancel_ir", bus.IR, 1'b1);
    check("rf_cancel_stock", bus.stock, 8'd5);
    bus.VE = 1'b0;
    wait_for(S_FULL, 1'b1, 100, "rf_full", n);
    repeat (8) cyc();
    check("rf_ir_count", ir_count, 17);
    check("rf_cap", bus.stock, 8'd20);
    exp_q.push_back(1'b0);
    bus.MOTOR = 1'b1;
    wait_for(S_EB, 1'b1, 60, "rf_eb", n);

    // Stock to 7, then reset with the next bottle between the stations.
    run_bottle(13, 7);
    wait_for(S_PG, 1'b1, 200, "rst_pg", n);
    wait_for(S_PG, 1'b0, 20, "rst_pg_leave", n);
    cyc();
    cyc();
    check("rst_pre_stock", bus.stock, 8'd7);
    reset = 1'b1;
    #1;
    check("rst_async_outs", {bus.PG, bus.CH, bus.RO, bus.CQ, bus.EB, bus.IR,
                             bus.overflow}, 7'b0);
    check("rst_async_stock", bus.stock, 8'd20);
    cyc();
    cyc();
    reset = 1'b0;
    wait_for(S_PG, 1'b1, 40, "rst_pg_again", n);
    check("rst_pos0", n, 16);
    check("sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
